ram_hs: RTL and testbench

//  Parametrised single-port RAM with a request/ready handshake, programmable wait states,
//  per-byte write enables and optional zero-fill after reset. Successor to the fixed 32x32

---
 rtl/ram_hs_pkg.sv | 24 ++
 rtl/ram_hs_array.sv | 45 ++++
 rtl/ram_hs.sv | 141 ++++++++++++++
 tb/tb_ram_hs.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_hs_pkg.sv
// Shared types for the handshaked single-port RAM: FSM state encoding,
// wait-state limit and a width helper for the wait counter.
package ram_hs_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int MAX_WAIT_STATES = 15;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ram_hs_array.sv
// Storage for ram_hs: DEPTH words with byte-lane writes and a registered
// read port that holds its value until the next read.
module ram_hs_array #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Contents are deliberately not reset; clearing is the parent's init sweep.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem_q[addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[addr];
  end

  always_ff @(posedge clock) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ram_hs.sv
// Single-port RAM behind a request/ready handshake with programmable wait
// states, per-byte writes and an optional zero-fill sweep after reset.
module ram_hs
  import ram_hs_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int WAIT_STATES   = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    chip_select,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    ready,
  output logic                    busy,
  output state_e                  dbg_state
);

  // Handshake: chip_select is a request qualifier looked at only in IDLE; the
  // request fields are captured on that edge and ignored afterwards. ready is
  // a one-cycle completion pulse, with read data valid on data_out during it.

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;
  localparam int CW    = clog2(WAIT_STATES + 1);
  localparam state_e RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;
  localparam logic   RESET_BUSY  = (INIT_ON_RESET != 0);

  state_e                  state_d, state_q;
  logic                    we_d, we_q;
  logic [NB-1:0]           be_d, be_q;
  logic [ADDR_WIDTH-1:0]   addr_d, addr_q;
  logic [DATA_WIDTH-1:0]   data_d, data_q;
  logic [CW-1:0]           cnt_d, cnt_q;
  logic [ADDR_WIDTH-1:0]   ptr_d, ptr_q;
  logic                    ready_d, ready_q;
  logic                    busy_d, busy_q;
  logic                    access;

  logic                    arr_wr_en;
  logic                    arr_rd_en;
  logic [NB-1:0]           arr_be;
  logic [ADDR_WIDTH-1:0]   arr_addr;
  logic [DATA_WIDTH-1:0]   arr_wdata;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    access  = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (chip_select) begin
          we_d    = we;
          be_d    = byte_en;
          addr_d  = address;
          data_d  = data_in;
          cnt_d   = CW'(WAIT_STATES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          access  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RESET_STATE;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= RESET_BUSY;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Writes are gated by reset so an aborted transaction never lands in storage.
  always_comb begin
    arr_wr_en = !reset && ((state_q == ST_INIT) || (access && we_q));
    arr_rd_en = access && !we_q;
    arr_be    = (state_q == ST_INIT) ? '1 : be_q;
    arr_addr  = (state_q == ST_INIT) ? ptr_q : addr_q;
    arr_wdata = (state_q == ST_INIT) ? '0 : data_q;
  end

  ram_hs_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (arr_wr_en),
    .wr_be   (arr_be),
    .rd_en   (arr_rd_en),
    .addr    (arr_addr),
    .wr_data (arr_wdata),
    .rd_data (data_out)
  );

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_hs.sv
// Directed bench for ram_hs: four instances covering wait-state and
// init-on-reset variants, with a reference model and read-data queue.
module tb_ram_hs;
  import ram_hs_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NB = DW / 8;
  localparam int NI = 4;

  logic          clock = 1'b0;
  always #5 clock = ~clock;

  logic          rst [NI];
  logic          cs  [NI];
  logic          we;
  logic [NB-1:0] be;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout [NI];
  logic          rdy  [NI];
  logic          bsy  [NI];
  state_e        dbg  [NI];

  int            ws_of [NI] = '{1, 0, 15, 1};
  logic [DW-1:0] model [NI][32];
  logic [DW-1:0] last_rd [NI];
  logic [DW-1:0] exp_q [$];
  int            n_cmp = 0;
  int            n_fail = 0;

  ram_hs #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(1),  .INIT_ON_RESET(1)) u_dut0 (
    .clock(clock), .reset(rst[0]), .chip_select(cs[0]), .we(we), .byte_en(be), .address(addr),
    .data_in(din), .data_out(dout[0]), .ready(rdy[0]), .busy(bsy[0]), .dbg_state(dbg[0]));
  ram_hs #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(0),  .INIT_ON_RESET(1)) u_dut1 (
    .clock(clock), .reset(rst[1]), .chip_select(cs[1]), .we(we), .byte_en(be), .address(addr),
    .data_in(din), .data_out(dout[1]), .ready(rdy[1]), .busy(bsy[1]), .dbg_state(dbg[1]));
  ram_hs #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(15), .INIT_ON_RESET(1)) u_dut2 (
    .clock(clock), .reset(rst[2]), .chip_select(cs[2]), .we(we), .byte_en(be), .address(addr),
    .data_in(din), .data_out(dout[2]), .ready(rdy[2]), .busy(bsy[2]), .dbg_state(dbg[2]));
  ram_hs #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(1),  .INIT_ON_RESET(0)) u_dut3 (
    .clock(clock), .reset(rst[3]), .chip_select(cs[3]), .we(we), .byte_en(be), .address(addr),
    .data_in(din), .data_out(dout[3]), .ready(rdy[3]), .busy(bsy[3]), .dbg_state(dbg[3]));

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called right after reset is released at a falling edge.
  task automatic wait_init(input int k);
    int   n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    do begin
      @(posedge clock); #1;
      n++;
      if (rdy[k]) seen = 1'b1;
    end while (bsy[k] && n < 100);
    check($sformatf("init_len_i%0d", k), n, 32);
    check($sformatf("init_no_ready_i%0d", k), {31'b0, seen}, 32'd0);
    check($sformatf("init_dout_i%0d", k), dout[k], 32'd0);
    for (int i = 0; i < 32; i++) model[k][i] = '0;
    last_rd[k] = '0;
  endtask

  task automatic txn(input int k, input logic w, input logic [NB-1:0] b,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    logic [DW-1:0] e;
    @(negedge clock);
    we = w; be = b; addr = a; din = d; cs[k] = 1'b1;
    if (!w) exp_q.push_back(model[k][a]);
    else for (int i = 0; i < NB; i++) if (b[i]) model[k][a][8*i +: 8] = d[8*i +: 8];
    @(posedge clock); #1;
    // Drop the request and scramble the fields while the access is pending.
    cs[k] = 1'b0; we = ~w; be = ~b; addr = ~a; din = ~d;
    n = 0;
    while (!rdy[k] && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check($sformatf("latency_i%0d_a%0d", k, a), n, ws_of[k] + 1);
    if (!w) begin
      e = exp_q.pop_front();
      check($sformatf("rd_data_i%0d_a%0d", k, a), dout[k], e);
      last_rd[k] = e;
    end else begin
      check($sformatf("wr_dout_hold_i%0d", k), dout[k], last_rd[k]);
    end
    check($sformatf("busy_done_i%0d", k), {31'b0, bsy[k]}, 32'd1);
    @(posedge clock); #1;
    check($sformatf("ready_pulse_i%0d", k), {31'b0, rdy[k]}, 32'd0);
    check($sformatf("busy_idle_i%0d", k), {31'b0, bsy[k]}, 32'd0);
  endtask

  // Starts a write and resets the instance on the edge where it would land.
  task automatic abort_write(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clock);
    we = 1'b1; be = '1; addr = a; din = d; cs[k] = 1'b1;
    @(posedge clock); #1;
    cs[k] = 1'b0;
    repeat (ws_of[k]) begin
      @(posedge clock); #1;
      check($sformatf("abort_no_ready_wait_i%0d", k), {31'b0, rdy[k]}, 32'd0);
    end
    @(negedge clock);
    rst[k] = 1'b1;
    @(posedge clock); #1;
    check($sformatf("abort_no_ready_i%0d", k), {31'b0, rdy[k]}, 32'd0);
    check($sformatf("abort_dout_i%0d", k), dout[k], 32'd0);
    last_rd[k] = '0;
    @(negedge clock);
    rst[k] = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [NB-1:0] rb;
    logic [DW-1:0] rd;
    int            last, pulses;

    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; cs[k] = 1'b0; last_rd[k] = '0;
      for (int i = 0; i < 32; i++) model[k][i] = '0;
    end
    we = 1'b0; be = '0; addr = '0; din = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_dout_i%0d", k), dout[k], 32'd0);
      check($sformatf("rst_ready_i%0d", k), {31'b0, rdy[k]}, 32'd0);
    end
    check("rst_busy_init", {29'b0, bsy[0], bsy[1], bsy[2]}, 32'd7);
    check("rst_busy_noinit", {31'b0, bsy[3]}, 32'd0);
    check("rst_state_init", 32'(dbg[0]), 32'(ST_INIT));
    check("rst_state_noinit", 32'(dbg[3]), 32'(ST_IDLE));

    @(negedge clock);
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    fork
      wait_init(0);
      wait_init(1);
      wait_init(2);
    join

    // Every word is zero after the sweep
    for (int i = 0; i < 32; i++) txn(0, 1'b0, '0, AW'(i), '0);

    // Full-word write then read
    txn(0, 1'b1, 4'hF, 5'd3, 32'hDEADBEEF);
    txn(0, 1'b0, 4'h0, 5'd3, 32'h0);

    // Byte-lane merge and an all-lanes-off write
    txn(0, 1'b1, 4'hF, 5'd7, 32'h11223344);
    txn(0, 1'b1, 4'b0101, 5'd7, 32'hAABBCCDD);
    txn(0, 1'b0, 4'h0, 5'd7, 32'h0);
    check("merge_value", last_rd[0], 32'h11BB33DD);
    txn(0, 1'b1, 4'h0, 5'd7, 32'hFFFFFFFF);
    txn(0, 1'b0, 4'h0, 5'd7, 32'h0);

    // chip_select held high: one accept per WAIT_STATES+3 cycles
    @(negedge clock);
    we = 1'b0; be = '0; addr = 5'd3; din = '0; cs[0] = 1'b1;
    last = -1; pulses = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clock); #1;
      if (rdy[0]) begin
        if (last >= 0) check("back_to_back_gap", i - last, ws_of[0] + 3);
        check("back_to_back_data", dout[0], model[0][3]);
        last = i;
        pulses++;
      end
    end
    cs[0] = 1'b0;
    check("back_to_back_pulses", pulses, 4);
    last_rd[0] = model[0][3];
    repeat (2) @(posedge clock);
    #1;
    check("back_to_back_idle", {31'b0, bsy[0]}, 32'd0);

    // Random byte-lane traffic
    for (int i = 0; i < 8; i++) begin
      ra = AW'($urandom_range(0, 31));
      rb = NB'($urandom_range(0, 15));
      rd = $urandom;
      txn(0, 1'b1, rb, ra, rd);
      txn(0, 1'b0, '0, ra, '0);
    end

    // Zero and fifteen wait states; read data held across writes
    txn(1, 1'b1, 4'hF, 5'd2, 32'hCAFEF00D);
    txn(1, 1'b0, 4'h0, 5'd2, 32'h0);
    txn(1, 1'b1, 4'hF, 5'd2, 32'h01020304);
    txn(1, 1'b1, 4'hF, 5'd4, 32'h0BADC0DE);
    check("hold_ws0", dout[1], 32'hCAFEF00D);
    txn(1, 1'b0, 4'h0, 5'd2, 32'h0);
    txn(2, 1'b1, 4'hF, 5'd31, 32'h87654321);
    txn(2, 1'b0, 4'h0, 5'd31, 32'h0);
    txn(2, 1'b1, 4'b1000, 5'd31, 32'h00000000);
    check("hold_ws15", dout[2], 32'h87654321);
    txn(2, 1'b0, 4'h0, 5'd31, 32'h0);

    // Reset during a pending write, with and without the zero-fill
    txn(0, 1'b1, 4'hF, 5'd9, 32'h77);
    abort_write(0, 5'd9, 32'h5);
    wait_init(0);
    txn(0, 1'b0, 4'h0, 5'd9, 32'h0);

    txn(3, 1'b1, 4'hF, 5'd9, 32'h77);
    abort_write(3, 5'd9, 32'h5);
    #1;
    check("noinit_busy_after_rst", {31'b0, bsy[3]}, 32'd0);
    txn(3, 1'b0, 4'h0, 5'd9, 32'h0);

    // Reset in the middle of the sweep restarts it from address 0
    txn(0, 1'b1, 4'hF, 5'd1, 32'h12345678);
    @(negedge clock);
    rst[0] = 1'b1;
    @(negedge clock);
    rst[0] = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    rst[0] = 1'b1;
    @(negedge clock);
    rst[0] = 1'b0;
    wait_init(0);
    txn(0, 1'b0, 4'h0, 5'd1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
